// File: rtl/alu_pkg.sv
// Opcode map, FSM state encodings and shifter modes shared by seq_alu,
// its control unit and the testbench.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SH_SLL = 3'd0,
    SH_SRL = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_mode_e;

endpackage

// File: rtl/seq_alu_shifter.sv
// Combinational W-bit barrel shifter / rotator.
// Ports: mode (shift kind), amount (0..W-1), din (operand), dout_c (result).
// Rotates are naturally modulo W because amount is $clog2(W) bits wide.
module seq_alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  shift_mode_e          mode,
  input  logic [$clog2(W)-1:0] amount,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout_c
);

  logic [2*W-1:0] rot;

  // Rotates shift a doubled copy so amount 0 needs no special case.
  always_comb begin
    rot    = '0;
    dout_c = din;
    case (mode)
      SH_SLL: dout_c = din << amount;
      SH_SRL: dout_c = din >> amount;
      SH_SRA: dout_c = $signed(din) >>> amount;
      SH_ROR: begin
        rot    = {din, din} >> amount;
        dout_c = rot[W-1:0];
      end
      SH_ROL: begin
        rot    = {din, din} << amount;
        dout_c = rot[2*W-1:W];
      end
      default: dout_c = din;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with start/busy/done handshake: single-cycle logic/shift ops,
// iterative signed Booth multiply and signed restoring divide.
// Ports: clock, clear (sync active-high), start, op[4:0], a, b (operands),
//        result[2W-1:0], busy, done (one-cycle pulse), div_zero.
// Build option: SEQ_ALU_FAST_MUL_EN selects a single-cycle combinational
// multiply instead of the W-cycle Booth sequence.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   result,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned SHW = $clog2(W);
  localparam int unsigned CW  = SHW + 1;
`ifdef SEQ_ALU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W:0]     acc_q, acc_d;      // Booth partial product / divide remainder
  logic [W-1:0]   mq_q, mq_d;        // Booth multiplier / divide quotient
  logic           qm1_q, qm1_d;      // Booth q[-1]
  logic [2*W-1:0] result_q, result_d;
  logic           busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic           last_iter;
  shift_mode_e    shift_mode;
  logic [W-1:0]   shift_c;
  logic [W:0]     m_ext, booth_sum, booth_acc;
  logic [W-1:0]   booth_mq;
  logic [W-1:0]   dvs_mag, div_quo, quo_s, rem_s;
  logic [W:0]     div_shift, div_trial, div_rem;
`ifdef SEQ_ALU_FAST_MUL_EN
  logic signed [2*W-1:0] fast_prod_c;
  assign fast_prod_c = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
`endif

  assign last_iter = (cnt_q == CW'(W - 1));

  // Shift kind from the live opcode; shift ops finish in the launch cycle.
  always_comb begin
    shift_mode = SH_SLL;
    case (op)
      OP_SHR:  shift_mode = SH_SRL;
      OP_SHRA: shift_mode = SH_SRA;
      OP_ROR:  shift_mode = SH_ROR;
      OP_ROL:  shift_mode = SH_ROL;
      default: shift_mode = SH_SLL;
    endcase
  end

  seq_alu_shifter #(.W(W)) u_shifter (
    .mode   (shift_mode),
    .amount (b[SHW-1:0]),
    .din    (a),
    .dout_c (shift_c)
  );

  // One radix-2 Booth step; acc is W+1 bits so subtracting the most-negative
  // multiplicand cannot overflow.
  always_comb begin
    m_ext = {a_q[W-1], a_q};
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[W], booth_sum[W:1]};
    booth_mq  = {booth_sum[0], mq_q[W-1:1]};
  end

  // One restoring-divide step on magnitudes, then sign fix-up of the outputs.
  always_comb begin
    dvs_mag   = b_q[W-1] ? -b_q : b_q;
    div_shift = {acc_q[W-1:0], mq_q[W-1]};
    div_trial = div_shift - {1'b0, dvs_mag};
    div_rem   = div_trial[W] ? div_shift : div_trial;
    div_quo   = {mq_q[W-2:0], ~div_trial[W]};
    quo_s     = (a_q[W-1] ^ b_q[W-1]) ? -div_quo : div_quo;
    rem_s     = a_q[W-1] ? -div_rem[W-1:0] : div_rem[W-1:0];
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL && !FAST_MUL)     state_d = ST_MUL;
          else if (op == OP_DIV && b != '0)  state_d = ST_DIV;
          else                               state_d = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: if (last_iter) state_d = ST_DONE;
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, registered alongside the state.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Datapath next values: operand latch, iteration registers, result.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dz_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          case (op)
            OP_ADD:  result_d = {{W{1'b0}}, a + b};
            OP_SUB:  result_d = {{W{1'b0}}, a - b};
            OP_AND:  result_d = {{W{1'b0}}, a & b};
            OP_OR:   result_d = {{W{1'b0}}, a | b};
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                     result_d = {{W{1'b0}}, shift_c};
            OP_NEG:  result_d = {{W{1'b0}}, -a};
            OP_NOT:  result_d = {{W{1'b0}}, ~a};
            OP_MUL: begin
`ifdef SEQ_ALU_FAST_MUL_EN
              result_d = fast_prod_c;
`else
              acc_d = '0;
              mq_d  = b;
              qm1_d = 1'b0;
`endif
            end
            OP_DIV: begin
              if (b == '0) begin
                result_d = {a, {W{1'b1}}};
                dz_d     = 1'b1;
              end else begin
                acc_d = '0;
                mq_d  = a[W-1] ? -a : a;
              end
            end
            default: result_d = '0;
          endcase
        end
      end
      ST_MUL: begin
        acc_d = booth_acc;
        mq_d  = booth_mq;
        qm1_d = mq_q[0];
        cnt_d = cnt_q + CW'(1);
        if (last_iter) result_d = {booth_acc[W-1:0], booth_mq};
      end
      ST_DIV: begin
        acc_d = div_rem;
        mq_d  = div_quo;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) result_d = {rem_s, quo_s};
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      qm1_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      qm1_q    <= qm1_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign result   = result_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (W=32): directed cases plus randomized
// operations against an arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          clear;
  logic          start;
  logic [4:0]    op;
  logic [W-1:0]  a, b;
  logic [2*W-1:0] result;
  logic          busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  seq_alu #(.W(W)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

`ifdef SEQ_ALU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // Reference result from plain arithmetic on signed/unsigned integers.
  function automatic logic [63:0] ref_result(input logic [4:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    int unsigned n;
    logic [31:0] t;
    longint sx, sy, q, r;
    n = int'(y % 32);
    t = x;
    case (o)
      OP_ADD:  return {32'h0, x + y};
      OP_SUB:  return {32'h0, x - y};
      OP_AND:  return {32'h0, x & y};
      OP_OR:   return {32'h0, x | y};
      OP_SHR:  return {32'h0, x >> n};
      OP_SHRA: begin
        sx = longint'($signed(x));
        for (int i = 0; i < int'(n); i++) sx = sx / 2 - ((sx < 0 && sx % 2 != 0) ? 1 : 0);
        return {32'h0, sx[31:0]};
      end
      OP_SHL:  return {32'h0, x << n};
      OP_ROR: begin
        for (int i = 0; i < int'(n); i++) t = {t[0], t[31:1]};
        return {32'h0, t};
      end
      OP_ROL: begin
        for (int i = 0; i < int'(n); i++) t = {t[30:0], t[31]};
        return {32'h0, t};
      end
      OP_NEG:  return {32'h0, 32'h0 - x};
      OP_NOT:  return {32'h0, ~x};
      OP_MUL: begin
        q = longint'($signed(x)) * longint'($signed(y));
        return q;
      end
      OP_DIV: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] o, input logic [31:0] y);
    if (o == OP_MUL) return FAST ? 1 : W + 1;
    if (o == OP_DIV) return (y == 32'h0) ? 1 : W + 1;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one op from IDLE, scramble inputs, poke a stray start while busy,
  // then check latency, result, div_zero and the return to IDLE.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    logic [63:0] exp_r;
    logic        exp_dz;
    int          lat, cyc;
    exp_r  = ref_result(o, x, y);
    exp_dz = (o == OP_DIV) && (y == 32'h0);
    lat    = ref_latency(o, y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 5'($urandom);
    cyc = 1;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    while (!done && cyc < 40) begin
      if (lat > 4 && cyc == 3) begin
        start = 1'b1;
        op    = OP_ADD;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(cyc), 64'(lat));
    check({tag, ".result"}, result, exp_r);
    check({tag, ".div_zero"}, 64'(div_zero), 64'(exp_dz));
    @(posedge clock); #1;
    check({tag, ".idle"}, 64'({done, busy}), 64'd0);
  endtask

  initial begin : stim
    logic [4:0]  ops [14];
    logic [4:0]  ro;
    logic [31:0] ra, rb;
    logic        seen_done;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_MUL, OP_DIV, OP_NEG, OP_NOT, 5'b11111};

    clear = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    check("reset.result", result, 64'h0);
    check("reset.flags", 64'({busy, done, div_zero}), 64'h0);

    run_op("add", OP_ADD, 32'd5, 32'd7);
    run_op("ror", OP_ROR, 32'h0000_0001, 32'd1);
    run_op("shra", OP_SHRA, 32'h8000_0000, 32'd4);
    run_op("shl0", OP_SHL, 32'hDEAD_BEEF, 32'd0);
    run_op("sub_wrap", OP_SUB, 32'd0, 32'd1);
    run_op("mul", OP_MUL, 32'hFFFF_FFFD, 32'd7);
    run_op("mul_minmin", OP_MUL, 32'h8000_0000, 32'h8000_0000);
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("div_zero", OP_DIV, 32'd9, 32'd0);
    run_op("div_minneg1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("unknown", 5'b00000, 32'h1234_5678, 32'h9ABC_DEF0);

    // Clear in the middle of an iterative op aborts it without a done pulse.
    op = FAST ? OP_DIV : OP_MUL; a = 32'd1234; b = 32'd17; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    check("clear.result", result, 64'h0);
    check("clear.flags", 64'({busy, done, div_zero}), 64'h0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) seen_done = 1'b1;
    end
    check("clear.no_done", 64'(seen_done), 64'h0);
    run_op("after_clear", OP_ADD, 32'hFFFF_FFFF, 32'd2);

    for (int i = 0; i < 40; i++) begin
      ro = ops[$urandom_range(0, 13)];
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(0, 40));
        default: rb = 32'($urandom);
      endcase
      run_op("rand", ro, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
